// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between a BCD value source and the seven-segment scan driver.
// The source loads values and controls blanking; the driver returns segment/anode lines.
interface seg7_scan_driver_if;
  logic [15:0] bcd;
  logic        load;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  ga;
  logic        frame;

  modport master (
    output bcd, load, blank,
    input  seg, ga, frame
  );

  modport slave (
    input  bcd, load, blank,
    output seg, ga, frame
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment driver with frame-synchronous value commit,
// optional leading-zero blanking and registered active-low outputs.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned    CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     disp_val_q, disp_val_d;
  logic [15:0]     pend_val_q, pend_val_d;
  logic            pend_q, pend_d;
  logic            commit_q, commit_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      ga_q, ga_d;
  logic            frame_q, frame_d;

  logic       tick;
  logic [3:0] nibble;
  logic       lead_zero;
  logic [6:0] dec;

  always_comb begin
    tick      = (div_cnt_q == CntMax);
    commit_d  = tick && (idx_q == 2'd3);
    div_cnt_d = tick ? '0 : div_cnt_q + CntW'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;

    disp_val_d = disp_val_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    // A load coinciding with the commit bypasses the pending buffer.
    if (bus.load) begin
      if (commit_d) begin
        disp_val_d = bus.bcd;
        pend_d     = 1'b0;
      end else begin
        pend_val_d = bus.bcd;
        pend_d     = 1'b1;
      end
    end else if (commit_d && pend_q) begin
      disp_val_d = pend_val_q;
      pend_d     = 1'b0;
    end
  end

  always_comb begin
    nibble = disp_val_q[{idx_q, 2'b00} +: 4];

    lead_zero = 1'b0;
    unique case (idx_q)
      2'd3:    lead_zero = (disp_val_q[15:12] == 4'd0);
      2'd2:    lead_zero = (disp_val_q[15:8] == 8'd0);
      2'd1:    lead_zero = (disp_val_q[15:4] == 12'd0);
      default: lead_zero = 1'b0;
    endcase

    case (nibble)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase

    if (bus.blank) begin
      seg_d = 7'h7F;
      ga_d  = 4'hF;
    end else begin
      seg_d = ((BLANK_LZ != 0) && lead_zero) ? 7'h7F : dec;
      ga_d  = ~(4'b0001 << idx_q);
    end
    // Delayed so the pulse lines up with the first digit0 output of the new frame.
    frame_d = commit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      idx_q      <= 2'd0;
      disp_val_q <= 16'd0;
      pend_val_q <= 16'd0;
      pend_q     <= 1'b0;
      commit_q   <= 1'b0;
      seg_q      <= 7'h7F;
      ga_q       <= 4'hF;
      frame_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      commit_q   <= commit_d;
      seg_q      <= seg_d;
      ga_q       <= ga_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.ga    = ga_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random loads/blanking, checked
// cycle by cycle against an arithmetic model of the scan schedule and commit rules.
module tb_seg7_scan_driver;

  localparam int unsigned SD    = 4;
  localparam int unsigned Frame = 4 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .SCAN_DIV (SD),
    .BLANK_LZ (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_cyc;
  logic [15:0] m_disp, m_pval;
  bit          m_pend, m_prev_commit;
  logic        cur_blank;
  logic [6:0]  seg_tab [0:9];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t, cyc=%0d)", tag, got, exp, $time, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc         = 0;
    m_disp        = 16'd0;
    m_pval        = 16'd0;
    m_pend        = 1'b0;
    m_prev_commit = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_seg"}, 16'(bus.seg), 16'h007F);
    check_val({tag, "_ga"}, 16'(bus.ga), 16'h000F);
    check_val({tag, "_frame"}, 16'(bus.frame), 16'h0000);
  endtask

  // One clock: drive inputs, predict the outputs of this edge, advance the model, compare.
  task automatic step(input logic ld, input logic [15:0] v);
    int unsigned idx, digit;
    bit          tick, commit, leading;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_ga;
    logic        exp_frame;
    bus.load  = ld;
    bus.bcd   = v;
    bus.blank = cur_blank;
    @(posedge clk);
    idx     = (m_cyc / SD) % 4;
    tick    = (m_cyc % SD) == SD - 1;
    commit  = tick && (idx == 3);
    digit   = (32'(m_disp) >> (4 * idx)) & 32'hF;
    leading = (idx > 0) && ((32'(m_disp) >> (4 * idx)) == 0);
    if (cur_blank) begin
      exp_seg = 7'h7F;
      exp_ga  = 4'hF;
    end else begin
      exp_seg = leading ? 7'h7F : (digit > 9) ? 7'b0111111 : seg_tab[digit];
      exp_ga  = 4'hF ^ 4'(1 << idx);
    end
    exp_frame = m_prev_commit;

    m_prev_commit = commit;
    if (ld) begin
      if (commit) begin
        m_disp = v;
        m_pend = 1'b0;
      end else begin
        m_pval = v;
        m_pend = 1'b1;
      end
    end else if (commit && m_pend) begin
      m_disp = m_pval;
      m_pend = 1'b0;
    end
    m_cyc++;

    #1;
    check_val("seg", 16'(bus.seg), 16'(exp_seg));
    check_val("ga", 16'(bus.ga), 16'(exp_ga));
    check_val("frame", 16'(bus.frame), 16'(exp_frame));
  endtask

  task automatic idle_until(input int unsigned phase);
    while ((m_cyc % Frame) != phase) step(1'b0, 16'd0);
  endtask

  initial begin
    logic [15:0] v;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    cur_blank = 1'b0;
    bus.load  = 1'b0;
    bus.bcd   = 16'd0;
    bus.blank = 1'b0;
    model_reset();

    // Reset and first frames with no load.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (40) step(1'b0, 16'd0);

    // Mid-frame load, visible only after the frame wrap.
    idle_until(6);
    step(1'b1, 16'h1234);
    repeat (40) step(1'b0, 16'd0);

    // Two loads in one frame: last wins.
    idle_until(1);
    step(1'b1, 16'h0007);
    repeat (3) step(1'b0, 16'd0);
    step(1'b1, 16'h0042);
    repeat (36) step(1'b0, 16'd0);

    // Load on the committing tick.
    idle_until(Frame - 1);
    step(1'b1, 16'h0987);
    repeat (20) step(1'b0, 16'd0);

    // Invalid nibble and embedded zero, then blank.
    step(1'b1, 16'h0A05);
    repeat (40) step(1'b0, 16'd0);
    cur_blank = 1'b1;
    repeat (6) step(1'b0, 16'd0);
    cur_blank = 1'b0;
    repeat (20) step(1'b0, 16'd0);

    // Reset during digit2 with a value pending.
    idle_until(5);
    step(1'b1, 16'h9999);
    idle_until(9);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    rst = 1'b0;
    model_reset();
    repeat (40) step(1'b0, 16'd0);

    // Random loads and blanking.
    repeat (400) begin
      v = 16'($urandom);
      case ($urandom_range(3))
        0: v = v & 16'h00FF;
        1: v = v & 16'h0FFF;
        2: v = v & 16'h000F;
        default: ;
      endcase
      cur_blank = ($urandom_range(9) == 0);
      step(($urandom_range(7) == 0), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
